branch_resolver: RTL and testbench

- Execute-side partner of the gshare predictor. It holds the PC and predicted direction of every in-flight branch, in program order, from fetch until the branch resolves in execute.
- When a branch resolves, it drives the predictor's update_en/update_val. The integration muxes update_pc onto the predictor's PC input when update_en=1.
- It flags mispredictions, squashes wrong-path entries, and keeps accuracy counters.

---
 rtl/lab4_branch_pkg.sv | 11 +
 rtl/branch_pred_queue.sv | 70 +++++++
 rtl/branch_resolver.sv | 89 ++++++++
 tb/tb_branch_resolver.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lab4_branch_pkg.sv
// Shared types for the branch resolver: one in-flight branch record and the PC width.
package lab4_branch_pkg;

    localparam int pc_nbits = 32;

    typedef struct packed {
        logic [pc_nbits-1:0] pc;
        logic                pred;
    } branch_entry_t;

endpackage

// File: rtl/branch_pred_queue.sv
// In-order circular queue of in-flight branches. The head entry is read
// combinationally so that execute can compare against it in the resolve cycle.
module branch_pred_queue
    import lab4_branch_pkg::*;
#(
    parameter int p_depth = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enq_val,
    output logic          enq_rdy,
    input  branch_entry_t enq_data,
    output logic          deq_val,
    input  logic          deq_rdy,
    output branch_entry_t deq_data
);

    localparam int ptr_nbits = $clog2(p_depth);

    branch_entry_t        mem [p_depth];
    logic [ptr_nbits-1:0] head_reg, head_next;
    logic [ptr_nbits-1:0] tail_reg, tail_next;
    logic [ptr_nbits:0]   count_reg, count_next;
    logic                 enq_fire;
    logic                 deq_fire;

    assign enq_rdy  = (count_reg != (ptr_nbits + 1)'(p_depth));
    assign deq_val  = (count_reg != '0);
    assign enq_fire = enq_val && enq_rdy;
    assign deq_fire = deq_val && deq_rdy;
    assign deq_data = mem[head_reg];

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (clear) begin
            // Pointers realign to zero so the next entry starts a fresh stream.
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (enq_fire) tail_next = tail_reg + 1'b1;
            if (deq_fire) head_next = head_reg + 1'b1;
            case ({enq_fire, deq_fire})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire && !clear && !reset) mem[tail_reg] <= enq_data;
    end

endmodule

// File: rtl/branch_resolver.sv
// Execute-side branch bookkeeping: trains the predictor on resolution, flags
// mispredictions, squashes wrong-path entries and counts accuracy.
module branch_resolver
    import lab4_branch_pkg::*;
#(
    parameter int p_depth     = 4,
    parameter int p_cnt_nbits = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enq_val,
    output logic                   enq_rdy,
    input  logic [pc_nbits-1:0]    enq_pc,
    input  logic                   enq_pred,
    input  logic                   resolve_val,
    output logic                   resolve_rdy,
    input  logic                   resolve_taken,
    input  logic                   flush,
    output logic                   update_en,
    output logic                   update_val,
    output logic [pc_nbits-1:0]    update_pc,
    output logic                   mispredict,
    output logic [p_cnt_nbits-1:0] num_branches,
    output logic [p_cnt_nbits-1:0] num_mispredicts
);

    branch_entry_t enq_entry;
    branch_entry_t head_entry;
    logic          resolve_fire;
    logic          resolve_ok;
    logic          resolve_wrong;
    logic          clear;

    logic                   update_en_reg;
    logic                   update_val_reg;
    logic [pc_nbits-1:0]    update_pc_reg;
    logic                   mispredict_reg;
    logic [p_cnt_nbits-1:0] num_branches_reg;
    logic [p_cnt_nbits-1:0] num_mispredicts_reg;

    assign enq_entry.pc   = enq_pc;
    assign enq_entry.pred = enq_pred;

    assign resolve_fire  = resolve_val && resolve_rdy;
    // A flush in the same cycle discards the resolve entirely.
    assign resolve_ok    = resolve_fire && !flush;
    assign resolve_wrong = resolve_ok && (resolve_taken ^ head_entry.pred);
    assign clear         = flush || resolve_wrong;

    branch_pred_queue #(
        .p_depth (p_depth)
    ) u_queue (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .enq_val  (enq_val),
        .enq_rdy  (enq_rdy),
        .enq_data (enq_entry),
        .deq_val  (resolve_rdy),
        .deq_rdy  (resolve_val),
        .deq_data (head_entry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            update_en_reg       <= 1'b0;
            update_val_reg      <= 1'b0;
            update_pc_reg       <= '0;
            mispredict_reg      <= 1'b0;
            num_branches_reg    <= '0;
            num_mispredicts_reg <= '0;
        end else begin
            update_en_reg  <= resolve_ok;
            update_val_reg <= resolve_ok && resolve_taken;
            update_pc_reg  <= resolve_ok ? head_entry.pc : '0;
            mispredict_reg <= resolve_wrong;
            if (resolve_ok)    num_branches_reg    <= num_branches_reg + 1'b1;
            if (resolve_wrong) num_mispredicts_reg <= num_mispredicts_reg + 1'b1;
        end
    end

    assign update_en       = update_en_reg;
    assign update_val      = update_val_reg;
    assign update_pc       = update_pc_reg;
    assign mispredict      = mispredict_reg;
    assign num_branches    = num_branches_reg;
    assign num_mispredicts = num_mispredicts_reg;

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed scenarios plus a randomized
// run against a list-based model of the in-flight branch window.
module tb_branch_resolver;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, enq_val, enq_pred, resolve_val, resolve_taken, flush;
    logic [31:0] enq_pc;
    logic        enq_rdy, resolve_rdy, update_en, update_val, mispredict;
    logic [31:0] update_pc, num_branches, num_mispredicts;

    branch_resolver #(.p_depth(DEPTH), .p_cnt_nbits(32)) dut (
        .clk(clk), .reset(reset),
        .enq_val(enq_val), .enq_rdy(enq_rdy), .enq_pc(enq_pc), .enq_pred(enq_pred),
        .resolve_val(resolve_val), .resolve_rdy(resolve_rdy), .resolve_taken(resolve_taken),
        .flush(flush), .update_en(update_en), .update_val(update_val), .update_pc(update_pc),
        .mispredict(mispredict), .num_branches(num_branches), .num_mispredicts(num_mispredicts)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        pred;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_nb, m_nm, m_pc;
    logic        m_en, m_val, m_mis;
    int          n_vec = 0;
    int          n_err = 0;

    // Advance the model by one clock using the current inputs, then let the DUT clock.
    task automatic tick();
        bit   res, enq, mis;
        ent_t h, e;
        res = resolve_val && (mq.size() > 0);
        enq = enq_val && (mq.size() < DEPTH);
        mis = 1'b0;
        m_en = 1'b0; m_val = 1'b0; m_pc = '0; m_mis = 1'b0;
        if (reset) begin
            mq.delete(); m_nb = '0; m_nm = '0;
        end else if (flush) begin
            mq.delete();
        end else begin
            if (res) begin
                h = mq[0];
                mis = (resolve_taken != h.pred);
                m_en = 1'b1; m_val = resolve_taken; m_pc = h.pc; m_mis = mis;
                m_nb = m_nb + 1;
                if (mis) begin
                    m_nm = m_nm + 1;
                    mq.delete();
                end else begin
                    void'(mq.pop_front());
                end
            end
            if (enq && !(res && mis)) begin
                e.pc = enq_pc; e.pred = enq_pred;
                mq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        enq_val = 0; enq_pc = '0; enq_pred = 0;
        resolve_val = 0; resolve_taken = 0; flush = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1; tick(); tick();
        reset = 0;
    endtask

    task automatic enq(input logic [31:0] pc, input logic pred);
        enq_val = 1; enq_pc = pc; enq_pred = pred;
        tick();
        enq_val = 0;
    endtask

    task automatic test_reset();
        enq_val = 1; enq_pc = 32'hdead; enq_pred = 1; tick();
        do_reset();
        n_vec++;
        if ({update_en, update_val, mispredict, enq_rdy, resolve_rdy} !== 5'b00010 ||
            update_pc !== 0 || num_branches !== 0 || num_mispredicts !== 0) begin
            n_err++;
            $display("FAIL reset: en=%b val=%b mis=%b enq_rdy=%b res_rdy=%b pc=%h nb=%0d nm=%0d, want 0 0 0 1 0 0 0 0",
                     update_en, update_val, mispredict, enq_rdy, resolve_rdy, update_pc, num_branches, num_mispredicts);
        end
        $display("test_reset done");
    endtask

    task automatic test_correct();
        do_reset();
        enq(32'h100, 1'b1);
        resolve_val = 1; resolve_taken = 1; tick(); resolve_val = 0;
        n_vec++;
        if (update_en !== 1 || update_val !== 1 || update_pc !== 32'h100 || mispredict !== 0 ||
            num_branches !== 1 || num_mispredicts !== 0) begin
            n_err++;
            $display("FAIL correct_update: en=%b val=%b pc=%h mis=%b nb=%0d nm=%0d, want 1 1 100 0 1 0",
                     update_en, update_val, update_pc, mispredict, num_branches, num_mispredicts);
        end
        tick();
        n_vec++;
        if (update_en !== 0 || update_pc !== 0) begin
            n_err++;
            $display("FAIL correct_pulse: en=%b pc=%h, want 0 0", update_en, update_pc);
        end
        $display("resolve pc=00000100 taken=1 -> correct");
    endtask

    task automatic test_mispredict_squash();
        do_reset();
        enq(32'h200, 1'b0); enq(32'h204, 1'b1); enq(32'h208, 1'b1);
        resolve_val = 1; resolve_taken = 1; tick();
        n_vec++;
        if (update_en !== 1 || update_pc !== 32'h200 || mispredict !== 1 || num_mispredicts !== 1 || resolve_rdy !== 0) begin
            n_err++;
            $display("FAIL squash_update: en=%b pc=%h mis=%b nm=%0d res_rdy=%b, want 1 200 1 1 0",
                     update_en, update_pc, mispredict, num_mispredicts, resolve_rdy);
        end
        tick();
        resolve_val = 0;
        n_vec++;
        if (update_en !== 0 || num_branches !== 1) begin
            n_err++;
            $display("FAIL squash_empty_resolve: en=%b nb=%0d, want 0 1", update_en, num_branches);
        end
        $display("resolve pc=00000200 taken=1 -> mispredict, squashed");
    endtask

    task automatic test_full();
        logic [31:0] want_pc;
        do_reset();
        for (int i = 0; i < 4; i++) enq(32'h300 + 32'(4 * i), 1'b1);
        enq_val = 1; enq_pc = 32'h310; enq_pred = 0;
        n_vec++;
        if (enq_rdy !== 0 || resolve_rdy !== 1) begin
            n_err++;
            $display("FAIL full_rdy: enq_rdy=%b res_rdy=%b, want 0 1", enq_rdy, resolve_rdy);
        end
        tick(); tick();
        enq_val = 0;
        resolve_val = 1; resolve_taken = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            want_pc = 32'h300 + 32'(4 * i);
            n_vec++;
            if (update_en !== 1 || update_pc !== want_pc || mispredict !== 0) begin
                n_err++;
                $display("FAIL full_drain_%0d: en=%b pc=%h mis=%b, want 1 %h 0", i, update_en, update_pc, mispredict, want_pc);
            end
            $display("resolve pc=%h taken=1", update_pc);
        end
        tick();
        resolve_val = 0;
        n_vec++;
        if (update_en !== 0 || num_branches !== 4 || resolve_rdy !== 0) begin
            n_err++;
            $display("FAIL full_fifth_dropped: en=%b nb=%0d res_rdy=%b, want 0 4 0", update_en, num_branches, resolve_rdy);
        end
    endtask

    task automatic test_flush_collision();
        do_reset();
        enq(32'h500, 1'b1); enq(32'h504, 1'b0);
        flush = 1; resolve_val = 1; resolve_taken = 0; enq_val = 1; enq_pc = 32'h508; enq_pred = 1;
        tick();
        idle_inputs();
        n_vec++;
        if (update_en !== 0 || num_branches !== 0 || num_mispredicts !== 0 || resolve_rdy !== 0) begin
            n_err++;
            $display("FAIL flush_collision: en=%b nb=%0d nm=%0d res_rdy=%b, want 0 0 0 0",
                     update_en, num_branches, num_mispredicts, resolve_rdy);
        end
        $display("flush with resolve+enq -> all discarded");
    endtask

    task automatic test_enq_during_mispredict();
        do_reset();
        enq(32'h3f0, 1'b0);
        resolve_val = 1; resolve_taken = 1; enq_val = 1; enq_pc = 32'h400; enq_pred = 1;
        tick();
        enq_val = 0;
        n_vec++;
        if (update_pc !== 32'h3f0 || mispredict !== 1 || resolve_rdy !== 0) begin
            n_err++;
            $display("FAIL enq_mispredict: pc=%h mis=%b res_rdy=%b, want 3f0 1 0", update_pc, mispredict, resolve_rdy);
        end
        tick();
        resolve_val = 0;
        n_vec++;
        if (update_en !== 0) begin
            n_err++;
            $display("FAIL enq_mispredict_dropped: en=%b, want 0", update_en);
        end
        $display("resolve pc=000003f0 with enq 00000400 -> dropped");
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            reset       = ($urandom_range(0, 199) == 0);
            flush       = ($urandom_range(0, 19) == 0);
            enq_val     = ($urandom_range(0, 9) < 6);
            enq_pc      = {$urandom_range(0, 65535), 2'b00};
            enq_pred    = $urandom_range(0, 1);
            resolve_val = ($urandom_range(0, 9) < 5);
            if (mq.size() > 0)
                resolve_taken = ($urandom_range(0, 3) == 0) ? !mq[0].pred : mq[0].pred;
            else
                resolve_taken = $urandom_range(0, 1);
            tick();
            n_vec++;
            if (update_en !== m_en || update_val !== m_val || update_pc !== m_pc || mispredict !== m_mis ||
                num_branches !== m_nb || num_mispredicts !== m_nm ||
                enq_rdy !== (mq.size() < DEPTH) || resolve_rdy !== (mq.size() > 0)) begin
                n_err++;
                $display("FAIL random_%0d: en=%b val=%b pc=%h mis=%b nb=%0d nm=%0d er=%b rr=%b, want %b %b %h %b %0d %0d %b %b",
                         c, update_en, update_val, update_pc, mispredict, num_branches, num_mispredicts,
                         enq_rdy, resolve_rdy, m_en, m_val, m_pc, m_mis, m_nb, m_nm,
                         mq.size() < DEPTH, mq.size() > 0);
            end
            if (m_en) $display("resolve pc=%h taken=%b mis=%b", m_pc, m_val, m_mis);
        end
        reset = 0;
        idle_inputs();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        m_nb = '0; m_nm = '0;
        test_reset();
        test_correct();
        test_mispredict_squash();
        test_full();
        test_flush_collision();
        test_enq_during_mispredict();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
